hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage RV32I core. It drives the IF/ID/EX stall, flush and bubble controls from the ID instruction word (the same word the ID-stage immediate generator decodes) and the ID/EX stage state. It handles load-use hazards, ID-resolved taken branches, and multi-cycle multiply occupancy of EX. It also holds the pipeline idle until start, and counts stall cycles.

---
 rtl/hazard_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: IF/ID/EX stall, flush and bubble sequencing for the 5-stage RV32I pipeline
// Ports:
//   clk_i, rst_i (async, active-high), start_i    clock, reset, leave IDLE
//   id_instr_i                                    instruction in IF/ID
//   idex_memread_i, idex_rd_i, idex_is_mul_i      ID/EX stage state
//   branch_taken_i                                ID-resolved taken branch
//   pc_write_o, ifid_write_o, ifid_flush_o        PC / IF/ID controls
//   idex_bubble_o, ex_hold_o, exmem_bubble_o      ID/EX / EX/MEM controls
//   state_o, stall_cnt_o                          FSM state, saturating stall counter
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      id_instr_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             idex_is_mul_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             ex_hold_o,
    output logic             exmem_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam int MCW   = $clog2(MUL_LAT) + 1;
    localparam bit MULTI = MUL_LAT > 1;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, MUL_BUSY = 2'b10} state_t;
    state_t         state, state_nx;
    logic [MCW-1:0] cnt, cnt_nx;
    logic [6:0]     opc;
    logic           rs1_used, rs2_used, load_use;
    assign opc      = id_instr_i[6:0];
    assign rs1_used = opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    assign rs2_used = opc inside {7'b0110011, 7'b0100011, 7'b1100011};
    assign load_use = idex_memread_i && idex_rd_i != 5'd0 &&
                      ((rs1_used && id_instr_i[19:15] == idex_rd_i) ||
                       (rs2_used && id_instr_i[24:20] == idex_rd_i));
    assign state_o  = state;
    always_comb begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        ex_hold_o      = 1'b0;
        exmem_bubble_o = 1'b0;
        state_nx       = state;
        cnt_nx         = cnt;
        if (state == IDLE) begin
            idex_bubble_o = 1'b1;
            state_nx      = start_i ? RUN : IDLE;
        end else if ((state == RUN && idex_is_mul_i && MULTI) || (state == MUL_BUSY && cnt != '0)) begin
            // MUL still occupies EX: freeze the front end and starve EX/MEM
            ex_hold_o      = 1'b1;
            exmem_bubble_o = 1'b1;
            state_nx       = MUL_BUSY;
            cnt_nx         = (state == RUN) ? MCW'(MUL_LAT - 2) : cnt - 1'b1;
        end else begin
            // RUN, or the final MUL EX cycle: ordinary hazard resolution
            state_nx = RUN;
            if (load_use) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_cnt_o <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state != IDLE && !pc_write_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule
